// File: rtl/led_pattern_pkg.sv
// Shared definitions for the LED pattern generator: mode codes, burst states
// and the prescaler half-period derivation.
package led_pattern_pkg;

  localparam logic [2:0] MODE_OFF   = 3'd0;
  localparam logic [2:0] MODE_ON    = 3'd1;
  localparam logic [2:0] MODE_SLOW  = 3'd2;
  localparam logic [2:0] MODE_FAST  = 3'd3;
  localparam logic [2:0] MODE_BURST = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2,
    ST_GAP  = 2'd3
  } burst_state_e;

  function automatic int half_period(input int clk_hz, input int hz);
    return clk_hz / (2 * hz);
  endfunction

  // A usable half period is an exact division and at least two cycles long.
  function automatic bit half_period_ok(input int clk_hz, input int hz);
    if (hz <= 0) return 1'b0;
    return ((clk_hz % (2 * hz)) == 0) && (half_period(clk_hz, hz) >= 2);
  endfunction

endpackage

// File: rtl/led_chan.sv
// One LED channel: registered mode, burst state machine and LED flop.
// Ticks and blink phases come from the shared prescalers in the top level.
module led_chan
  import led_pattern_pkg::*;
#(
  parameter int GAP_SLOW = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] mode,
  input  logic [2:0] burst_n,
  input  logic       slow_tick,
  input  logic       fast_tick,
  input  logic       slow_ph,
  input  logic       fast_ph,
  output logic       led
);

  localparam logic [3:0] GAP_LAST = 4'(GAP_SLOW - 1);

  logic [2:0]   mode_r, mode_nx_s;
  burst_state_e state_r, state_nx_s;
  logic [2:0]   pcnt_r, pcnt_nx_s;
  logic [3:0]   gcnt_r, gcnt_nx_s;
  logic         led_r, led_nx_s;

  assign led = led_r;

  // Next-state and LED decode; disable beats a mode change, which beats any tick.
  always_comb begin
    mode_nx_s  = mode;
    state_nx_s = state_r;
    led_nx_s   = led_r;
    pcnt_nx_s  = pcnt_r;
    gcnt_nx_s  = gcnt_r;
    if (!en) begin
      state_nx_s = ST_IDLE;
      led_nx_s   = 1'b0;
      pcnt_nx_s  = 3'd0;
      gcnt_nx_s  = 4'd0;
    end else if (mode != mode_r) begin
      state_nx_s = ST_IDLE;
      led_nx_s   = 1'b0;
      gcnt_nx_s  = 4'd0;
    end else begin
      case (mode_r)
        MODE_ON: begin
          state_nx_s = ST_IDLE;
          led_nx_s   = 1'b1;
        end
        // Blinking follows the shared phase so equal-mode channels never drift apart.
        MODE_SLOW: begin
          state_nx_s = ST_IDLE;
          if (slow_tick) led_nx_s = slow_ph;
          else           led_nx_s = led_r;
        end
        MODE_FAST: begin
          state_nx_s = ST_IDLE;
          if (fast_tick) led_nx_s = fast_ph;
          else           led_nx_s = led_r;
        end
        MODE_BURST: begin
          case (state_r)
            ST_IDLE: begin
              if (fast_tick) begin
                pcnt_nx_s  = (burst_n == 3'd0) ? 3'd1 : burst_n;
                led_nx_s   = 1'b1;
                state_nx_s = ST_HI;
              end else begin
                led_nx_s   = 1'b0;
              end
            end
            ST_HI: begin
              if (fast_tick) begin
                led_nx_s  = 1'b0;
                pcnt_nx_s = pcnt_r - 3'd1;
                if (pcnt_r <= 3'd1) begin
                  state_nx_s = ST_GAP;
                  gcnt_nx_s  = 4'd0;
                end else begin
                  state_nx_s = ST_LO;
                end
              end else begin
                led_nx_s = led_r;
              end
            end
            ST_LO: begin
              if (fast_tick) begin
                led_nx_s   = 1'b1;
                state_nx_s = ST_HI;
              end else begin
                led_nx_s   = led_r;
              end
            end
            ST_GAP: begin
              led_nx_s = 1'b0;
              if (slow_tick) begin
                if (gcnt_r >= GAP_LAST) begin
                  state_nx_s = ST_IDLE;
                  gcnt_nx_s  = 4'd0;
                end else begin
                  gcnt_nx_s  = gcnt_r + 4'd1;
                end
              end else begin
                gcnt_nx_s = gcnt_r;
              end
            end
            default: begin
              state_nx_s = ST_IDLE;
              led_nx_s   = 1'b0;
            end
          endcase
        end
        default: begin
          state_nx_s = ST_IDLE;
          led_nx_s   = 1'b0;
        end
      endcase
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_r  <= MODE_OFF;
      state_r <= ST_IDLE;
      pcnt_r  <= 3'd0;
      gcnt_r  <= 4'd0;
      led_r   <= 1'b0;
    end else begin
      mode_r  <= mode_nx_s;
      state_r <= state_nx_s;
      pcnt_r  <= pcnt_nx_s;
      gcnt_r  <= gcnt_nx_s;
      led_r   <= led_nx_s;
    end
  end

endmodule

// File: rtl/led_pattern.sv
// Multi-channel LED pattern generator: shared slow/fast prescalers drive
// NCH independent channels selecting off/on/blink/burst patterns.
module led_pattern
  import led_pattern_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int CLK_HZ   = 50_000_000,
  parameter int SLOW_HZ  = 1,
  parameter int FAST_HZ  = 4,
  parameter int GAP_SLOW = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [3*NCH-1:0] mode,
  input  logic [2:0]       burst_n,
  output logic [NCH-1:0]   led,
  output logic             slow_tick
);

  localparam int SLOW_HALF = half_period(CLK_HZ, SLOW_HZ);
  localparam int FAST_HALF = half_period(CLK_HZ, FAST_HZ);
  localparam int SW        = $clog2(SLOW_HALF);
  localparam int FW        = $clog2(FAST_HALF);
  localparam logic [SW-1:0] SLOW_LAST = SW'(SLOW_HALF - 1);
  localparam logic [FW-1:0] FAST_LAST = FW'(FAST_HALF - 1);

  if (!half_period_ok(CLK_HZ, SLOW_HZ)) begin : g_bad_slow
    $fatal(1, "led_pattern: SLOW_HZ does not give an exact half period of at least 2");
  end
  if (!half_period_ok(CLK_HZ, FAST_HZ)) begin : g_bad_fast
    $fatal(1, "led_pattern: FAST_HZ does not give an exact half period of at least 2");
  end
  if (NCH < 1 || NCH > 16 || GAP_SLOW < 1 || GAP_SLOW > 15) begin : g_bad_range
    $fatal(1, "led_pattern: NCH or GAP_SLOW out of range");
  end

  logic [SW-1:0] scnt_r;
  logic [FW-1:0] fcnt_r;
  logic          stick_r, ftick_r, sph_r, fph_r;

  assign slow_tick = stick_r;

  // Slow prescaler; the phase bit flips with each wrap so channels can share it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scnt_r <= {SW{1'b0}}; stick_r <= 1'b0; sph_r <= 1'b0;
    end else if (!en) begin
      scnt_r <= {SW{1'b0}}; stick_r <= 1'b0; sph_r <= 1'b0;
    end else if (scnt_r == SLOW_LAST) begin
      scnt_r <= {SW{1'b0}}; stick_r <= 1'b1; sph_r <= ~sph_r;
    end else begin
      scnt_r <= scnt_r + SW'(1'b1); stick_r <= 1'b0;
    end
  end

  // Fast prescaler, same structure as the slow one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fcnt_r <= {FW{1'b0}}; ftick_r <= 1'b0; fph_r <= 1'b0;
    end else if (!en) begin
      fcnt_r <= {FW{1'b0}}; ftick_r <= 1'b0; fph_r <= 1'b0;
    end else if (fcnt_r == FAST_LAST) begin
      fcnt_r <= {FW{1'b0}}; ftick_r <= 1'b1; fph_r <= ~fph_r;
    end else begin
      fcnt_r <= fcnt_r + FW'(1'b1); ftick_r <= 1'b0;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    led_chan #(.GAP_SLOW(GAP_SLOW)) u_chan (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .mode      (mode[3*i +: 3]),
      .burst_n   (burst_n),
      .slow_tick (stick_r),
      .fast_tick (ftick_r),
      .slow_ph   (sph_r),
      .fast_ph   (fph_r),
      .led       (led[i])
    );
  end

endmodule

// File: tb/tb_led_pattern.sv
// Randomized bench for led_pattern with a timeline-based reference model
// (edges since enable, burst start time and pulse arithmetic).
module tb_led_pattern;

  localparam int NCH = 2;
  localparam int SH  = 16 / (2 * 1);
  localparam int FH  = 16 / (2 * 4);
  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic [5:0] mode = 6'd0;
  logic [2:0] burst_n = 3'd0;
  logic [1:0] led;
  logic       slow_tick;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int k;
  int mmode[NCH];
  bit mled[NCH];
  bit bidle[NCH];
  int bstart[NCH];
  int bn[NCH];
  int gseen[NCH];

  led_pattern #(.NCH(2), .CLK_HZ(16), .SLOW_HZ(1), .FAST_HZ(4), .GAP_SLOW(2)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .burst_n(burst_n),
    .led(led), .slow_tick(slow_tick)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    k = 0;
    for (int c = 0; c < NCH; c++) begin
      mmode[c] = 0; mled[c] = 1'b0; bidle[c] = 1'b1;
      bstart[c] = 0; bn[c] = 1; gseen[c] = 0;
    end
  endfunction

  // Advance the reference by one clock edge using the inputs sampled there.
  function automatic void model_edge();
    bit sact, fact;
    int sph, fph, d, ge, m;
    if (!en) begin
      k = 0;
      for (int c = 0; c < NCH; c++) begin
        mmode[c] = int'(mode[3*c +: 3]); mled[c] = 1'b0; bidle[c] = 1'b1;
      end
    end else begin
      k++;
      sact = (k > 1) && ((k - 1) % SH == 0);
      fact = (k > 1) && ((k - 1) % FH == 0);
      sph  = ((k - 1) / SH) % 2;
      fph  = ((k - 1) / FH) % 2;
      for (int c = 0; c < NCH; c++) begin
        m = int'(mode[3*c +: 3]);
        if (m != mmode[c]) begin
          mmode[c] = m; mled[c] = 1'b0; bidle[c] = 1'b1;
        end else begin
          case (mmode[c])
            1: mled[c] = 1'b1;
            2: if (sact) mled[c] = sph[0];
            3: if (fact) mled[c] = fph[0];
            4: begin
              if (bidle[c]) begin
                if (fact) begin
                  bstart[c] = k; bn[c] = (burst_n == 3'd0) ? 1 : int'(burst_n);
                  gseen[c] = 0; bidle[c] = 1'b0; mled[c] = 1'b1;
                end
              end else begin
                d  = k - bstart[c];
                ge = (2 * bn[c] - 1) * FH;
                if (d < ge) mled[c] = ((d / FH) % 2 == 0);
                else begin
                  mled[c] = 1'b0;
                  if (d > ge && sact) begin
                    gseen[c]++;
                    if (gseen[c] == GAP) bidle[c] = 1'b1;
                  end
                end
              end
            end
            default: mled[c] = 1'b0;
          endcase
        end
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    for (int c = 0; c < NCH; c++)
      check_eq($sformatf("led%0d", c), int'(led[c]), int'(mled[c]));
    check_eq("slow_tick", int'(slow_tick), int'(k > 0 && k % SH == 0));
  endtask

  task automatic rst_pulse();
    rst = 1'b0;
    #1;
    check_eq("rst_led", int'(led), 0);
    check_eq("rst_slow_tick", int'(slow_tick), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic edges_until_led0(input string tag, input bit level, input int exp);
    int n;
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (led[0] == level) begin n = i; break; end
    end
    check_eq(tag, n, exp);
  endtask

  initial begin
    int len, found;
    model_reset();
    #1;
    check_eq("reset_led", int'(led), 0);
    check_eq("reset_slow_tick", int'(slow_tick), 0);
    @(negedge clk);
    rst = 1'b1;

    // Slow blink timing from enable.
    mode = {3'd0, 3'd2}; burst_n = 3'd3;
    repeat (3) step();
    en = 1'b1;
    edges_until_led0("slow_first_rise", 1'b1, 9);
    edges_until_led0("slow_toggle", 1'b0, 8);

    // ch1 fast alongside ch0 slow.
    mode = {3'd3, 3'd2};
    repeat (20) step();

    // FAST to ON mid-period, then an undefined code.
    mode = {3'd3, 3'd3};
    repeat (7) step();
    mode = {3'd3, 3'd1};
    step(); check_eq("on_switch_edge", int'(led[0]), 0);
    step(); check_eq("on_next_edge", int'(led[0]), 1);
    mode = {3'd3, 3'd6};
    repeat (4) begin step(); check_eq("code6_off", int'(led[0]), 0); end

    // Bursts of three, then disable while high.
    mode = {3'd2, 3'd4}; burst_n = 3'd3;
    repeat (40) step();
    found = 0;
    for (int i = 0; i < 60; i++) begin step(); if (led[0]) begin found = 1; break; end end
    check_eq("burst_hi_found", found, 1);
    en = 1'b0;
    step(); check_eq("en_low_led", int'(led[0]), 0);
    repeat (2) step();
    en = 1'b1;
    edges_until_led0("reenable_rise", 1'b1, 3);

    // Reset mid-pulse behaves like power-up.
    rst_pulse();
    edges_until_led0("rst_reenable_rise", 1'b1, 3);
    burst_n = 3'd0;
    repeat (60) step();

    // Randomized segments.
    for (int s = 0; s < 40; s++) begin
      for (int c = 0; c < NCH; c++)
        mode[3*c +: 3] = ($urandom_range(0, 9) < 7) ? 3'($urandom_range(2, 4)) : 3'($urandom_range(0, 7));
      burst_n = 3'($urandom_range(0, 7));
      len = $urandom_range(10, 90);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 39) == 0) burst_n = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 79) == 0) en = 1'b0;
        else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
        if ($urandom_range(0, 149) == 0) rst_pulse();
        step();
      end
      en = 1'b1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_pattern.md
LED_PATTERN -- requirements
Module: led_pattern

Interface
REQ-001 Parameter NCH, default 4: number of independent LED channels, range 1..16.
REQ-002 Parameter CLK_HZ, default 50_000_000: clk frequency in Hz.
REQ-003 Parameter SLOW_HZ, default 1: slow blink rate in Hz.
REQ-004 Parameter FAST_HZ, default 4: fast blink and burst pulse rate in Hz.
REQ-005 Parameter GAP_SLOW, default 2: burst gap length, in slow ticks, range 1..15.
REQ-006 clk  input  1  system clock; reset rst, asynchronous, active-low; clock clk.
REQ-007 rst  input  1  asynchronous active-low reset.
REQ-008 en  input  1  global enable; low forces all LEDs off and clears all timing.
REQ-009 mode  input  3*NCH  per-channel mode code; channel i uses bits [3i+2:3i].
REQ-010 burst_n  input  3  pulses per burst, shared by all channels; 0 is treated as 1.
REQ-011 led  output  NCH  registered LED drive, one bit per channel.
REQ-012 slow_tick  output  1  one-cycle strobe at each slow half-period wrap, for synchronising other blocks.

Function
REQ-013 Derived constants: SLOW_HALF = CLK_HZ/(2*SLOW_HZ) and FAST_HALF = CLK_HZ/(2*FAST_HZ); elaboration SHALL fail if either value is < 2 or its division leaves a remainder.
REQ-014 Two shared prescalers SHALL each count 0..HALF-1 while en=1, wrap to 0, and strobe their tick for exactly the wrap cycle; prescaler width = clog2(HALF).
REQ-015 The first tick of each prescaler SHALL occur HALF clock edges after the first edge at which en is sampled 1.
REQ-016 Mode codes: 0 OFF, 1 ON, 2 SLOW, 3 FAST, 4 BURST; codes 5-7 SHALL behave as OFF.
REQ-017 OFF: led=0. ON: led=1. Both take effect on the edge after the new mode is sampled (one-cycle latency).
REQ-018 SLOW / FAST: led toggles on each slow / fast tick; all channels in the same mode stay in phase with each other.
REQ-019 Each channel SHALL register its mode; any change clears led to 0 and returns the burst FSM to IDLE on the same edge; the new pattern starts at the next relevant tick.
REQ-020 BURST FSM per channel, states IDLE, HI, LO, GAP, advancing only on fast ticks except in GAP.
REQ-021 IDLE, on fast tick: load pcnt = max(burst_n,1), set led=1, go to HI; burst_n is sampled only here.
REQ-022 HI, on fast tick: set led=0 and decrement pcnt; if the result is 0 go to GAP, else go to LO.
REQ-023 LO, on fast tick: set led=1 and go to HI.
REQ-024 GAP: led=0; count slow ticks; on the GAP_SLOW-th slow tick after entry, go to IDLE.
REQ-025 A slow tick and a fast tick on the same edge SHALL each be honoured in its own state; a mode change on that edge takes priority over both ticks.
REQ-026 en=0 SHALL, on each edge: clear both prescalers, clear all led, set every FSM to IDLE, and hold slow_tick=0.

Reset
REQ-027 rst=0 SHALL immediately clear led, slow_tick, prescalers, registered modes, pcnt and gap counters, and set every FSM to IDLE.
REQ-028 Reset asserted mid-burst SHALL abort the burst; after release, behaviour is identical to power-up.

Structure
REQ-029 Package led_pattern_pkg SHALL hold the mode-code constants, the burst state enumeration and the half-period derivation function.
REQ-030 Sub-module led_chan SHALL implement one channel (mode register, burst FSM, led flop) and be instantiated NCH times; the prescalers stay in the top level.

Verification (NCH=2, CLK_HZ=16, SLOW_HZ=1, FAST_HZ=4, GAP_SLOW=2, so SLOW_HALF=8 and FAST_HALF=2)
REQ-031 en=1 with ch0 in SLOW -> led[0] rises 8 edges after en is sampled 1, then toggles every 8 cycles; slow_tick pulses every 8 cycles.
REQ-032 ch0 SLOW and ch1 FAST -> led[1] toggles every 2 cycles; led[0] is unaffected.
REQ-033 ch0 BURST with burst_n=3 -> three 2-high/2-low pulses, then led=0 until the 2nd slow tick after GAP entry, then the pattern repeats.
REQ-034 burst_n=0 in BURST -> exactly one pulse per burst; changing burst_n mid-burst changes only the next burst.
REQ-035 Switch ch0 from FAST to ON mid-period -> led[0]=0 on the switch edge, then 1 on the following edge; a switch to code 6 -> led stays 0.
REQ-036 Deassert en mid-burst, or pulse rst low, in the HI state -> led=0 immediately; on re-enable, the first pulse starts 2 edges after en is sampled 1.
